// File: rtl/pipe_adder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_adder_if : operand/result valid-ready bus for pipe_adder; zero/neg/ |
// | ovf flags exist only with PIPE_ADDER_FLAGS_EN.         rev 1.0           |
// +--------------------------------------------------------------------------+
interface pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             cout;
`ifdef PIPE_ADDER_FLAGS_EN
  logic             zero;
  logic             neg;
  logic             ovf;
`endif

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, res, cout
`ifdef PIPE_ADDER_FLAGS_EN
    , output zero, neg, ovf
`endif
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, res, cout
`ifdef PIPE_ADDER_FLAGS_EN
    , input zero, neg, ovf
`endif
  );
endinterface
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_adder : pipelined ripple-carry adder, CHUNK bits per stage, whole-  |
// | pipe stall on back-pressure. Optional flags: PIPE_ADDER_FLAGS_EN. rev 1.0|
// +--------------------------------------------------------------------------+
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_adder_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;

  logic adv;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand B shrinks by one slice per stage; A shares a register with the
    // finished result slices, so its MSB survives until the last stage.
    localparam int PW = WIDTH - k * CHUNK;

    logic             prev_valid;
    logic             prev_carry;
    logic [WIDTH-1:0] prev_ar;
    logic [PW-1:0]    prev_b;
    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] ar_new;

    logic             valid_d;
    logic             valid_q;
    logic             carry_d;
    logic             carry_q;
    logic [WIDTH-1:0] ar_d;
    logic [WIDTH-1:0] ar_q;

    if (k == 0) begin : g_src_in
      assign prev_valid = bus.in_valid;
      assign prev_carry = bus.cin;
      assign prev_ar    = bus.a;
      assign prev_b     = bus.b;
    end else begin : g_src_stage
      assign prev_valid = g_stage[k-1].valid_q;
      assign prev_carry = g_stage[k-1].carry_q;
      assign prev_ar    = g_stage[k-1].ar_q;
      assign prev_b     = g_stage[k-1].g_fwd.b_rem_q;
    end

    always_comb begin
      slice_sum = {1'b0, prev_ar[k*CHUNK +: CHUNK]} + {1'b0, prev_b[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, prev_carry};
      ar_new                   = prev_ar;
      ar_new[k*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
      valid_d = valid_q;
      carry_d = carry_q;
      ar_d    = ar_q;
      if (adv) begin
        valid_d = prev_valid;
        carry_d = slice_sum[CHUNK];
        ar_d    = ar_new;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        ar_q    <= '0;
      end else begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        ar_q    <= ar_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [PW-CHUNK-1:0] b_rem_d;
      logic [PW-CHUNK-1:0] b_rem_q;

      always_comb begin
        b_rem_d = b_rem_q;
        if (adv) begin
          b_rem_d = prev_b[PW-1:CHUNK];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          b_rem_q <= '0;
        end else begin
          b_rem_q <= b_rem_d;
        end
      end
    end else begin : g_out
      assign bus.out_valid = valid_q;
      assign bus.res       = ar_q;
      assign bus.cout      = carry_q;

`ifdef PIPE_ADDER_FLAGS_EN
      logic zero_d;
      logic zero_q;
      logic neg_d;
      logic neg_q;
      logic ovf_d;
      logic ovf_q;

      // prev_ar[WIDTH-1] is still the original A MSB: only this stage overwrites it.
      always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        ovf_d  = ovf_q;
        if (adv) begin
          zero_d = (ar_new == '0);
          neg_d  = ar_new[WIDTH-1];
          ovf_d  = (prev_ar[WIDTH-1] == prev_b[PW-1]) &&
                   (ar_new[WIDTH-1] != prev_ar[WIDTH-1]);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
          ovf_q  <= 1'b0;
        end else begin
          zero_q <= zero_d;
          neg_q  <= neg_d;
          ovf_q  <= ovf_d;
        end
      end

      assign bus.zero = zero_q;
      assign bus.neg  = neg_q;
      assign bus.ovf  = ovf_q;
`endif
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// tb_pipe_adder: directed vectors and scoreboarded streams for pipe_adder,
// WIDTH=32 with CHUNK=8 (four stages) and CHUNK=32 (single stage).
module tb_pipe_adder;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int N_OPS  = 100;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pipe_adder_if #(.WIDTH(WIDTH)) bus4 ();
  pipe_adder_if #(.WIDTH(WIDTH)) bus1 ();

  pipe_adder #(.WIDTH(WIDTH), .CHUNK(8))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  pipe_adder #(.WIDTH(WIDTH), .CHUNK(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated op on the 4-stage DUT; exp_flags = {zero, neg, ovf}.
  task automatic single_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic c, input logic [31:0] exp_res, input logic exp_cout,
                           input logic [2:0] exp_flags);
    int lat;
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 1'b1;
    bus4.a         = a;
    bus4.b         = b;
    bus4.cin       = c;
    #1;
    check({tag, " in_ready"}, 64'(bus4.in_ready), 64'd1);
    lat = 0;
    do begin
      tick();
      bus4.in_valid = 1'b0;
      bus4.a        = 32'hDEAD_BEEF;
      bus4.b        = 32'hCAFE_F00D;
      bus4.cin      = 1'b1;
      lat++;
    end while (!bus4.out_valid && lat < 20);
    check({tag, " latency"}, 64'(lat), 64'(STAGES));
    check({tag, " res"},  64'(bus4.res),  64'(exp_res));
    check({tag, " cout"}, 64'(bus4.cout), 64'(exp_cout));
`ifdef PIPE_ADDER_FLAGS_EN
    check({tag, " flags"}, 64'({bus4.zero, bus4.neg, bus4.ovf}), 64'(exp_flags));
`else
    if (exp_flags === 3'bxxx) $display("note: unexpected flag vector");
`endif
    tick();
    check({tag, " drained"}, 64'(bus4.out_valid), 64'd0);
  endtask

  task automatic run_stream(input string tag, input bit bp);
    logic [32:0] exp_q[$];
    logic [32:0] exp_v;
    logic [31:0] ca;
    logic [31:0] cb;
    logic        cc;
    logic [31:0] held_res;
    logic        held_cout;
    logic        held;
    logic        acc_in;
    logic        acc_out;
    int          sent;
    int          got;
    int          iter;
    sent = 0;
    got  = 0;
    iter = 0;
    held = 1'b0;
    held_res  = '0;
    held_cout = 1'b0;
    ca = $urandom;
    cb = $urandom;
    cc = 1'($urandom_range(0, 1));
    while (got < N_OPS && iter < 2000) begin
      bus4.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus4.in_valid  = (sent < N_OPS);
      bus4.a         = ca;
      bus4.b         = cb;
      bus4.cin       = cc;
      #1;
      if (held) begin
        check({tag, " hold valid"}, 64'(bus4.out_valid), 64'd1);
        check({tag, " hold res"},   64'(bus4.res),       64'(held_res));
        check({tag, " hold cout"},  64'(bus4.cout),      64'(held_cout));
      end
      if (bp)
        check({tag, " in_ready"}, 64'(bus4.in_ready), 64'(!bus4.out_valid || bus4.out_ready));
      else
        check({tag, " in_ready"}, 64'(bus4.in_ready), 64'd1);
      acc_in    = bus4.in_valid && bus4.in_ready;
      acc_out   = bus4.out_valid && bus4.out_ready;
      held      = bus4.out_valid && !bus4.out_ready;
      held_res  = bus4.res;
      held_cout = bus4.cout;
      if (acc_out) begin
        check({tag, " pending"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check({tag, " res"},  64'(bus4.res),  64'(exp_v[31:0]));
          check({tag, " cout"}, 64'(bus4.cout), 64'(exp_v[32]));
        end
        got++;
      end
      if (acc_in) begin
        exp_q.push_back({1'b0, ca} + {1'b0, cb} + 33'(cc));
        sent++;
        ca = $urandom;
        cb = $urandom;
        cc = 1'($urandom_range(0, 1));
      end
      tick();
      iter++;
    end
    check({tag, " count"}, 64'(got), 64'(N_OPS));
    if (!bp) check({tag, " cycles"}, 64'(iter), 64'(N_OPS + STAGES));
  endtask

  initial begin
    int lat;
    int seen;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b1;
    tick();
    tick();
    check("reset out_valid", 64'(bus4.out_valid), 64'd0);
    check("reset res",       64'(bus4.res),       64'd0);
    check("reset cout",      64'(bus4.cout),      64'd0);
    check("reset in_ready",  64'(bus4.in_ready),  64'd1);
    rst_n = 1'b1;
    tick();

    single_op("add small",  32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 3'b000);
    single_op("full carry", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 3'b100);
    single_op("pos ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 3'b011);
    single_op("neg ovf",    32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 3'b101);
    single_op("mid carry",  32'h00FF_00FF, 32'h0001_0001, 1'b1, 32'h0100_0101, 1'b0, 3'b000);

    run_stream("stream", 1'b0);
    run_stream("backpr", 1'b1);

    // Three ops in flight, then a one-cycle reset.
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus4.in_valid = 1'b1;
      bus4.a        = 32'h1234_5678 + 32'(i);
      bus4.b        = 32'h0F0F_0F0F;
      bus4.cin      = 1'b1;
      tick();
    end
    bus4.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("flush out_valid", 64'(bus4.out_valid), 64'd0);
    check("flush res",       64'(bus4.res),       64'd0);
    check("flush cout",      64'(bus4.cout),      64'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus4.out_valid) seen++;
    end
    check("flush stale", 64'(seen), 64'd0);

    // Single-stage instance: latency 1.
    bus1.in_valid = 1'b1;
    bus1.a        = 32'hFFFF_FFFF;
    bus1.b        = 32'h0000_0001;
    bus1.cin      = 1'b0;
    lat = 0;
    do begin
      tick();
      bus1.in_valid = 1'b0;
      lat++;
    end while (!bus1.out_valid && lat < 20);
    check("s1 latency", 64'(lat),       64'd1);
    check("s1 res",     64'(bus1.res),  64'h0);
    check("s1 cout",    64'(bus1.cout), 64'd1);
`ifdef PIPE_ADDER_FLAGS_EN
    check("s1 flags", 64'({bus1.zero, bus1.neg, bus1.ovf}), 64'(3'b100));
`endif
    tick();
    check("s1 drained", 64'(bus1.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
